// File: rtl/econ_pkg.sv
// Shared definitions for the econ encoder front end: frame geometry, sample and
// frame types, and the collector state encoding.
package econ_pkg;

  localparam int N_SAMPLES = 48;
  localparam int SAMPLE_W  = 8;
  localparam int FRAME_W   = N_SAMPLES * SAMPLE_W;
  localparam int IDX_W     = $clog2(N_SAMPLES);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [FRAME_W-1:0]  frame_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } coll_state_e;

endpackage

// File: rtl/econ_frame_reg.sv
// Single-entry valid/ready output register. A load may land in the same cycle
// the current entry drains, which keeps back-to-back frames gapless.
module econ_frame_reg
  import econ_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  frame_t load_data_i,
  output logic   load_ok_o,
  output logic   valid_o,
  output frame_t data_o,
  input  logic   ready_i
);

  logic   valid_q;
  frame_t data_q;

  // Free when empty, or when the held entry leaves on this edge.
  assign load_ok_o = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i && load_ok_o) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/econ_input_packer.sv
// Packs a byte-serial, sof-marked sample stream into 48-sample frames and hands
// them to the encoder through a one-frame output register.
module econ_input_packer
  import econ_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  sample_t       s_data,
  input  logic          s_sof,
  input  logic          s_valid,
  output logic          s_ready,
  output frame_t        m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt
);

  coll_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] slot;
  frame_t           coll_q;
  frame_t           coll_d;
  logic [15:0]      frame_cnt_q;
  logic [15:0]      drop_cnt_q;
  logic             s_fire;
  logic             last_slot;
  logic             load_ok;
  logic             handoff;

  assign s_ready   = (state_q != ST_FULL);
  assign s_fire    = s_valid && s_ready;
  assign last_slot = (state_q == ST_FILL) && s_fire && !s_sof &&
                     (idx_q == IDX_W'(N_SAMPLES - 1));
  assign handoff   = (last_slot || (state_q == ST_FULL)) && load_ok;

  // Slot write; coll_d already contains the final sample when the frame completes,
  // so it is what gets handed to the output register.
  always_comb begin
    coll_d = coll_q;
    slot   = s_sof ? '0 : idx_q;
    if (s_fire && (s_sof || (state_q == ST_FILL))) begin
      coll_d[int'(slot)*SAMPLE_W +: SAMPLE_W] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    coll_q <= coll_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (handoff) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (s_fire && s_sof) begin
            idx_q   <= IDX_W'(1);
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (s_fire) begin
            if (s_sof) begin
              if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
              end
              idx_q <= IDX_W'(1);
            end else if (last_slot) begin
              idx_q   <= '0;
              state_q <= load_ok ? ST_IDLE : ST_FULL;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_FULL: begin
          if (load_ok) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  econ_frame_reg u_frame_reg (
    .clk         (clk),
    .reset       (reset),
    .load_i      (handoff),
    .load_data_i (coll_d),
    .load_ok_o   (load_ok),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .ready_i     (m_ready)
  );

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_econ_input_packer.sv
// Bench for econ_input_packer: a sample-queue model of the packer is checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_econ_input_packer;
  import econ_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  sample_t     s_data;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;
  frame_t      m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  econ_input_packer dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  // Model: samples gather in a byte queue; a completed frame waits as "held"
  // until the output slot is free or draining.
  bit          mdlCollecting;
  byte unsigned mdlQ[$];
  bit          mdlHeld;
  frame_t      mdlHeldData;
  bit          mdlOutValid;
  frame_t      mdlOutData;
  logic [15:0] mdlFrameCnt;
  logic [15:0] mdlDropCnt;
  bit          mdlOutFree;

  function automatic frame_t packQueue(input byte unsigned q[$]);
    frame_t f = '0;
    for (int k = 0; k < q.size(); k++) f[8*k +: 8] = q[k];
    return f;
  endfunction

  function automatic logic [7:0] sampleOf(input int seed, input int k);
    return 8'((seed * 37 + k * 11 + 5) & 255);
  endfunction

  function automatic frame_t makeFrame(input int seed);
    frame_t f = '0;
    for (int k = 0; k < N_SAMPLES; k++) f[8*k +: 8] = sampleOf(seed, k);
    return f;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mdlCollecting = 1'b0;
      mdlQ.delete();
      mdlHeld       = 1'b0;
      mdlHeldData   = '0;
      mdlOutValid   = 1'b0;
      mdlOutData    = '0;
      mdlFrameCnt   = '0;
      mdlDropCnt    = '0;
    end else begin
      mdlOutFree = !mdlOutValid || m_ready;
      if (s_valid && !mdlHeld) begin
        if (s_sof) begin
          if (mdlCollecting && mdlDropCnt != 16'hFFFF) mdlDropCnt = mdlDropCnt + 16'd1;
          mdlQ.delete();
          mdlQ.push_back(s_data);
          mdlCollecting = 1'b1;
        end else if (mdlCollecting) begin
          mdlQ.push_back(s_data);
          if (mdlQ.size() == N_SAMPLES) begin
            mdlHeldData   = packQueue(mdlQ);
            mdlHeld       = 1'b1;
            mdlCollecting = 1'b0;
            mdlQ.delete();
          end
        end
      end
      if (mdlOutValid && m_ready) mdlOutValid = 1'b0;
      if (mdlHeld && mdlOutFree) begin
        mdlOutValid = 1'b1;
        mdlOutData  = mdlHeldData;
        mdlHeld     = 1'b0;
        mdlFrameCnt = mdlFrameCnt + 16'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [FRAME_W-1:0] act,
                             input logic [FRAME_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("s_ready",   FRAME_W'(s_ready),   FRAME_W'(!mdlHeld));
      checkOutput("m_valid",   FRAME_W'(m_valid),   FRAME_W'(mdlOutValid));
      checkOutput("m_data",    m_data,              mdlOutData);
      checkOutput("frame_cnt", FRAME_W'(frame_cnt), FRAME_W'(mdlFrameCnt));
      checkOutput("drop_cnt",  FRAME_W'(drop_cnt),  FRAME_W'(mdlDropCnt));
    end
  end

  task automatic applyStimulus(input logic v, input logic sof, input logic [7:0] d);
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int seed);
    for (int k = 0; k < N_SAMPLES; k++) applyStimulus(1'b1, k == 0, sampleOf(seed, k));
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_s_ready",   FRAME_W'(s_ready),   FRAME_W'(1));
    checkOutput("rst_m_valid",   FRAME_W'(m_valid),   FRAME_W'(0));
    checkOutput("rst_m_data",    m_data,              '0);
    checkOutput("rst_frame_cnt", FRAME_W'(frame_cnt), FRAME_W'(0));
    checkOutput("rst_drop_cnt",  FRAME_W'(drop_cnt),  FRAME_W'(0));

    $display("[TB] ramp frame 0x00..0x2F");
    for (int k = 0; k < N_SAMPLES; k++) applyStimulus(1'b1, k == 0, 8'(k));
    checkOutput("ramp_m_valid",  FRAME_W'(m_valid),        FRAME_W'(1));
    checkOutput("ramp_first",    FRAME_W'(m_data[7:0]),    FRAME_W'(8'h00));
    checkOutput("ramp_last",     FRAME_W'(m_data[383:376]), FRAME_W'(8'h2F));
    checkOutput("ramp_frames",   FRAME_W'(frame_cnt),      FRAME_W'(1));
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] 50 back-to-back frames");
    doReset();
    for (int f = 0; f < 50; f++) sendFrame(f + 100);
    checkOutput("b2b_last_data", m_data, makeFrame(149));
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("b2b_frames", FRAME_W'(frame_cnt), FRAME_W'(50));

    $display("[TB] backpressure across two frames");
    doReset();
    m_ready = 1'b0;
    sendFrame(7);
    checkOutput("bp_first_out", m_data, makeFrame(7));
    sendFrame(8);
    checkOutput("bp_s_ready_low", FRAME_W'(s_ready), FRAME_W'(0));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'hEE);
    checkOutput("bp_hold_data", m_data, makeFrame(7));
    m_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bp_second_out", m_data, makeFrame(8));
    checkOutput("bp_second_vld", FRAME_W'(m_valid), FRAME_W'(1));
    checkOutput("bp_s_ready_up", FRAME_W'(s_ready), FRAME_W'(1));
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bp_drained", FRAME_W'(m_valid), FRAME_W'(0));
    checkOutput("bp_frames",  FRAME_W'(frame_cnt), FRAME_W'(2));

    $display("[TB] partial frame then sof");
    doReset();
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, k == 0, 8'(8'hA0 + k));
    sendFrame(21);
    checkOutput("drop_one",   FRAME_W'(drop_cnt), FRAME_W'(1));
    checkOutput("drop_frame", m_data, makeFrame(21));
    checkOutput("drop_slot0", FRAME_W'(m_data[7:0]), FRAME_W'(sampleOf(21, 0)));
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] samples without sof, reset mid-frame");
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 8'(8'h55 + k));
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("nosof_m_valid", FRAME_W'(m_valid),  FRAME_W'(0));
    checkOutput("nosof_drop",    FRAME_W'(drop_cnt), FRAME_W'(0));
    m_ready = 1'b0;
    sendFrame(33);
    for (int k = 0; k < 29; k++) applyStimulus(1'b1, k == 0, sampleOf(34, k));
    checkOutput("pre_rst_valid", FRAME_W'(m_valid), FRAME_W'(1));
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, sampleOf(34, 29));
    reset = 1'b0;
    m_ready = 1'b1;
    checkOutput("midrst_m_valid", FRAME_W'(m_valid),   FRAME_W'(0));
    checkOutput("midrst_frames",  FRAME_W'(frame_cnt), FRAME_W'(0));
    checkOutput("midrst_drop",    FRAME_W'(drop_cnt),  FRAME_W'(0));
    for (int k = 30; k < 40; k++) applyStimulus(1'b1, 1'b0, sampleOf(34, k));
    sendFrame(35);
    checkOutput("midrst_frame", m_data, makeFrame(35));
    checkOutput("midrst_drop2", FRAME_W'(drop_cnt), FRAME_W'(0));
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] drop counter saturation");
    doReset();
    for (int i = 0; i < 32'h10001; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    checkOutput("drop_sat", FRAME_W'(drop_cnt), FRAME_W'(16'hFFFF));
    applyStimulus(1'b1, 1'b1, 8'h11);
    checkOutput("drop_sat_hold", FRAME_W'(drop_cnt), FRAME_W'(16'hFFFF));
    applyStimulus(1'b0, 1'b0, 8'h00);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/econ_input_packer.md
# econ_input_packer

Upstream stage of the `econ_4x4_d10` encoder. It takes a byte-serial stream of 8-bit sensor samples with start-of-frame marking and assembles 48 samples into one 384-bit frame. Frames are presented on a valid/ready port that connects directly to the encoder's `input_1_rsc_dat/vld/rdy`. A collector plus a one-frame output register let the next frame fill while the current one waits for the encoder.

## Interface
- `N_SAMPLES`, 48: samples per frame.
- `SAMPLE_W`, 8: bits per sample.
- `FRAME_W`, `N_SAMPLES*SAMPLE_W` = 384: output frame width.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: reset, synchronous, active-high.
- `s_data` in `SAMPLE_W`: input sample.
- `s_sof` in 1: marks sample 0 of a frame; qualified by `s_valid`.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: packer accepts the sample this cycle.
- `m_data` out `FRAME_W`: assembled frame, to encoder `input_1_rsc_dat`.
- `m_valid` out 1: frame valid, to `input_1_rsc_vld`.
- `m_ready` in 1: encoder accepts, from `input_1_rsc_rdy`.
- `frame_cnt` out 16: frames handed off, wraps at 2^16.
- `drop_cnt` out 16: partial frames discarded, saturates at 0xFFFF.

## Operation
- A sample transfer occurs when `s_valid && s_ready`. A frame transfer occurs when `m_valid && m_ready`.
- Packing: sample k of the frame (k=0 is the `s_sof` sample) goes to `m_data[8k+7:8k]`.
- Collector FSM:
  - IDLE: `s_ready`=1. Samples without `s_sof` are discarded and not counted. A sample with `s_sof` is written to slot 0, sets idx=1, and moves to FILL.
  - FILL: `s_ready`=1.
    - Sample without sof: write slot idx, idx++.
    - Sample with sof: `drop_cnt`++ (saturating), write slot 0, idx=1, stay in FILL.
    - Accepting slot 47 (with idx=47 and no sof): attempt handoff.
  - FULL: `s_ready`=0. Holds the complete frame until the output register is free, then hands off and goes to IDLE.
- Handoff: copy the collector into the output register, set `m_valid`, and increment `frame_cnt`.
  - Handoff is allowed when the output register is empty, or is emptying this cycle (`m_valid && m_ready`).
  - From FILL, if handoff is allowed the FSM goes directly to IDLE; otherwise it goes to FULL.
- Output register: `m_data` is stable while `m_valid`=1 and `m_ready`=0. `m_valid` clears on a frame transfer unless a handoff occurs in the same cycle, in which case it stays high with the new data.
- `s_ready` is purely a function of FSM state (low only in FULL). It has no combinational path from `m_ready`.
- Reset:
  - Effect: FSM to IDLE, idx=0, `m_valid`=0, `m_data`=0, `frame_cnt`=0, `drop_cnt`=0, `s_ready`=1 from the first post-reset cycle.
  - A reset mid-frame discards all partial and pending data without incrementing `drop_cnt`.

## Timing
- Latency: 48th sample accepted at edge t; `m_valid`=1 and `m_data` valid after edge t (cycle t+1), provided the output register was free.
- Throughput: one frame per 48 cycles with continuous `s_valid` and `m_ready`=1. There are no bubbles between frames: a sof sample is accepted in the cycle right after the 48th sample.
- Backpressure:
  - Collector finishes while output is held: FULL, `s_ready`=0 from cycle t+1.
  - `m_ready` goes high at edge u: output takes the new frame at u, and `s_ready`=1 from u+1.
- Simultaneous frame transfer and handoff in one cycle: no gap in `m_valid`, and `frame_cnt` increments once.
- `drop_cnt` saturation: held at 0xFFFF. `frame_cnt` wraps 0xFFFF→0.

## Structure
- Shared package `econ_pkg`: `N_SAMPLES`, `SAMPLE_W`, `FRAME_W`, `frame_t` (384-bit), `sample_t`, and the collector state enum (IDLE/FILL/FULL). The encoder wrapper and the bench reuse these.
- One sub-module, `econ_frame_reg`: a single-entry valid/ready register with load/accept logic and simultaneous load-and-drain. The top holds the FSM, slot-write decoder and counters.

## Test plan
- Reset, then 48 samples with values 0x00..0x2F, sof on the first, `m_ready`=1. Required: `m_valid` one cycle after the last sample, `m_data[7:0]`=0x00, `m_data[383:376]`=0x2F, `frame_cnt`=1.
- 50 back-to-back frames taken from `tb_input_features.mem` (sample k is bits [8k+7:8k] of each line). Required: `m_data` equals each file line, one frame per 48 cycles, `s_ready` never low, `frame_cnt`=50.
- Hold `m_ready`=0 across two complete frames. Required: the first frame is stable on `m_data`, `s_ready`=0 after the second completes. Then release `m_ready`: both frames delivered in order, with no loss.
- Frame A is 20 samples, then a sof arrives. Required: `drop_cnt`=1, the next 48 samples form a frame with the new sof sample in slot 0.
- 5 samples without sof after reset. Required: discarded, no output, `drop_cnt`=0. Assert `reset` at sample 30 of a frame: `m_valid`=0, counters 0, the next sof frame packs correctly.
- Drive 0x10000 forced drops. Required: `drop_cnt` stays at 0xFFFF.
